zeroheti_clic_lite: RTL and testbench

ZEROHETI_CLIC_LITE -- requirements
Module: zeroheti_clic_lite

---
 rtl/zeroheti_clic_lite.sv | 164 ++++++++++++++++
 tb/tb_zeroheti_clic_lite.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_clic_lite.sv
// Lightweight CLIC: per-source pending/enable/level state, registered max-level arbiter.
// Optional selective-hardware-vectoring storage is enabled by defining ZEROHETI_CLIC_SHV_EN.
module zeroheti_clic_lite #(
    parameter int NumIrqs = 32,
    localparam int IdW    = $clog2(NumIrqs)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumIrqs-1:0] intr_src_i,
    input  logic [7:0]         thresh_i,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [IdW-1:0]     cfg_id_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic               cfg_rvalid_o,
    output logic               irq_o,
    output logic [IdW-1:0]     irq_id_o,
    output logic [7:0]         irq_level_o,
    output logic               irq_shv_o,
    output logic [1:0]         irq_priv_o,
    input  logic               irq_ack_i,
    input  logic [IdW-1:0]     irq_ack_id_i
);

    localparam logic [IdW:0] NumIrqsW = (IdW + 1)'(NumIrqs);

    logic [NumIrqs-1:0]      src_q, src_d;
    logic [NumIrqs-1:0]      src_prev_q, src_prev_d;
    logic [NumIrqs-1:0]      ip_q, ip_d;
    logic [NumIrqs-1:0]      ie_q, ie_d;
    logic [NumIrqs-1:0]      edge_q, edge_d;
    logic [NumIrqs-1:0][7:0] level_q, level_d;
    logic [NumIrqs-1:0]      shv_q, shv_d;

    logic                    irq_q, irq_d;
    logic [IdW-1:0]          irq_id_q, irq_id_d;
    logic [7:0]              irq_level_q, irq_level_d;
    logic                    irq_shv_q, irq_shv_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;

    logic [NumIrqs-1:0]      rise;
    logic [NumIrqs-1:0]      ip_eff;
    logic                    cfg_in_range;
    logic                    best_found;
    logic [7:0]              best_lvl;
    logic [IdW-1:0]          best_id;
    logic                    best_shv;
    logic                    unused_wdata;

    assign unused_wdata = ^{cfg_wdata_i[31:16], cfg_wdata_i[7:3]};

    assign cfg_in_range = ({1'b0, cfg_id_i} < NumIrqsW);
    assign rise         = src_q & ~src_prev_q;
    // Level-triggered sources follow the registered line directly.
    assign ip_eff       = (edge_q & ip_q) | (~edge_q & src_q);

    always_comb begin
        src_d      = intr_src_i;
        src_prev_d = src_q;
        ip_d       = ip_q;
        ie_d       = ie_q;
        edge_d     = edge_q;
        level_d    = level_q;
        shv_d      = shv_q;
        rdata_d    = '0;
        rvalid_d   = cfg_req_i;
        for (int i = 0; i < NumIrqs; i++) begin
            if (edge_q[i]) begin
                if (irq_ack_i && (irq_ack_id_i == IdW'(i))) begin
                    ip_d[i] = 1'b0;
                end
                if (rise[i]) begin
                    ip_d[i] = 1'b1;
                end
            end else begin
                ip_d[i] = 1'b0;
            end
            // Config access is applied last so a write overrides ack and edge updates.
            if (cfg_req_i && cfg_in_range && (cfg_id_i == IdW'(i))) begin
                if (cfg_we_i) begin
                    ie_d[i]    = cfg_wdata_i[0];
                    edge_d[i]  = cfg_wdata_i[2];
                    ip_d[i]    = cfg_wdata_i[2] & cfg_wdata_i[1];
                    level_d[i] = cfg_wdata_i[15:8];
`ifdef ZEROHETI_CLIC_SHV_EN
                    shv_d[i]   = cfg_wdata_i[3];
`else
                    shv_d[i]   = 1'b0;
`endif
                end else begin
                    rdata_d = {16'h0000, level_q[i], 4'h0, shv_q[i], edge_q[i], ip_eff[i], ie_q[i]};
                end
            end
        end
    end

    always_comb begin
        best_found = 1'b0;
        best_lvl   = 8'h00;
        best_id    = '0;
        best_shv   = 1'b0;
        // Ascending scan with >= hands ties to the highest ID.
        for (int i = 0; i < NumIrqs; i++) begin
            if (ie_q[i] && ip_eff[i] && (level_q[i] != 8'h00) && (level_q[i] > thresh_i)
                && (!best_found || (level_q[i] >= best_lvl))) begin
                best_found = 1'b1;
                best_lvl   = level_q[i];
                best_id    = IdW'(i);
                best_shv   = shv_q[i];
            end
        end
        irq_d       = best_found && !irq_ack_i;
        irq_id_d    = irq_d ? best_id : '0;
        irq_level_d = irq_d ? best_lvl : 8'h00;
        irq_shv_d   = irq_d & best_shv;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q       <= '0;
            src_prev_q  <= '0;
            ip_q        <= '0;
            ie_q        <= '0;
            edge_q      <= '0;
            level_q     <= '0;
            shv_q       <= '0;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
            irq_level_q <= 8'h00;
            irq_shv_q   <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            src_q       <= src_d;
            src_prev_q  <= src_prev_d;
            ip_q        <= ip_d;
            ie_q        <= ie_d;
            edge_q      <= edge_d;
            level_q     <= level_d;
            shv_q       <= shv_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_id_d;
            irq_level_q <= irq_level_d;
            irq_shv_q   <= irq_shv_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign cfg_rdata_o  = rdata_q;
    assign cfg_rvalid_o = rvalid_q;
    assign irq_o        = irq_q;
    assign irq_id_o     = irq_id_q;
    assign irq_level_o  = irq_level_q;
    assign irq_priv_o   = 2'b11;
`ifdef ZEROHETI_CLIC_SHV_EN
    assign irq_shv_o    = irq_shv_q;
`else
    assign irq_shv_o    = 1'b0;
`endif

endmodule

// File: tb/tb_zeroheti_clic_lite.sv
// Directed bench for zeroheti_clic_lite with 12 sources (so an out-of-range ID is encodable).
module tb_zeroheti_clic_lite;

    localparam int N   = 12;
    localparam int IdW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    intr_src;
    logic [7:0]      thresh;
    logic            cfg_req, cfg_we;
    logic [IdW-1:0]  cfg_id;
    logic [31:0]     cfg_wdata, cfg_rdata;
    logic            cfg_rvalid;
    logic            irq, irq_shv;
    logic [IdW-1:0]  irq_id;
    logic [7:0]      irq_level;
    logic [1:0]      irq_priv;
    logic            ack;
    logic [IdW-1:0]  ack_id;

    int n_cmp = 0;
    int n_err = 0;

    zeroheti_clic_lite #(.NumIrqs(N)) dut (
        .clk_i(clk), .rst_i(rst), .intr_src_i(intr_src), .thresh_i(thresh),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_id_i(cfg_id), .cfg_wdata_i(cfg_wdata),
        .cfg_rdata_o(cfg_rdata), .cfg_rvalid_o(cfg_rvalid),
        .irq_o(irq), .irq_id_o(irq_id), .irq_level_o(irq_level), .irq_shv_o(irq_shv),
        .irq_priv_o(irq_priv), .irq_ack_i(ack), .irq_ack_id_i(ack_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [IdW-1:0] id, input logic [31:0] data);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_id = id; cfg_wdata = data;
        tick();
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_wdata = '0;
        n_cmp++;
        if (cfg_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL wr_rvalid id=%0d: got %b want 1", id, cfg_rvalid);
        end
    endtask

    task automatic cfg_rd(input logic [IdW-1:0] id, input logic [31:0] exp, input string name);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_id = id;
        tick();
        cfg_req = 1'b0;
        n_cmp++;
        if ({cfg_rvalid, cfg_rdata} !== {1'b1, exp}) begin
            n_err++;
            $display("FAIL %s: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", name, cfg_rvalid, cfg_rdata, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({irq, irq_id, irq_level, irq_shv, cfg_rvalid, cfg_rdata, irq_priv} !== {1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 32'h0, 2'b11}) begin
            n_err++;
            $display("FAIL reset_outputs: got irq=%b id=%0d lvl=%h rvalid=%b rdata=%h priv=%b want zeros priv=11",
                     irq, irq_id, irq_level, cfg_rvalid, cfg_rdata, irq_priv);
        end
        cfg_rd(4'd6, 32'h0, "reset_read6");
        tick();
        n_cmp++;
        if ({cfg_rvalid, cfg_rdata} !== 33'h0) begin
            n_err++;
            $display("FAIL rvalid_idle: got rvalid=%b rdata=%h want 0", cfg_rvalid, cfg_rdata);
        end
    endtask

    task automatic test_edge();
        cfg_wr(4'd5, 32'h0000_4005);
        intr_src[5] = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL edge_early: got irq=%b want 0", irq);
        end
        tick();
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b1, 4'd5, 8'h40}) begin
            n_err++; $display("FAIL edge_irq: got irq=%b id=%0d lvl=%h want 1/5/40", irq, irq_id, irq_level);
        end
        intr_src[5] = 1'b0;
        ack = 1'b1; ack_id = 4'd5;
        tick();
        ack = 1'b0;
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b0, 4'd0, 8'h00}) begin
            n_err++; $display("FAIL edge_ack: got irq=%b id=%0d lvl=%h want 0/0/00", irq, irq_id, irq_level);
        end
        tick(); tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL edge_stay_low: got irq=%b want 0", irq);
        end
        cfg_wr(4'd5, 32'h0);
    endtask

    task automatic test_arbitration();
        cfg_wr(4'd3, 32'h0000_8007);
        cfg_wr(4'd9, 32'h0000_8007);
        cfg_wr(4'd2, 32'h0000_C007);
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b1, 4'd9, 8'h80}) begin
            n_err++; $display("FAIL arb_tie: got irq=%b id=%0d lvl=%h want 1/9/80", irq, irq_id, irq_level);
        end
        tick();
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b1, 4'd2, 8'hC0}) begin
            n_err++; $display("FAIL arb_max: got irq=%b id=%0d lvl=%h want 1/2/C0", irq, irq_id, irq_level);
        end
        ack = 1'b1; ack_id = 4'd2;
        cfg_wr(4'd2, 32'h0000_C004);
        ack = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL arb_suppress: got irq=%b want 0", irq);
        end
        tick();
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b1, 4'd9, 8'h80}) begin
            n_err++; $display("FAIL arb_next: got irq=%b id=%0d lvl=%h want 1/9/80", irq, irq_id, irq_level);
        end
        cfg_rd(4'd2, 32'h0000_C004, "arb_read2");
        cfg_wr(4'd3, 32'h0);
        cfg_wr(4'd9, 32'h0);
        cfg_wr(4'd2, 32'h0);
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL arb_cleared: got irq=%b want 0", irq);
        end
    endtask

    task automatic test_level_thresh();
        thresh = 8'h20;
        cfg_wr(4'd7, 32'h0000_2001);
        intr_src[7] = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL thresh_equal: got irq=%b want 0", irq);
        end
        thresh = 8'h1F;
        tick();
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b1, 4'd7, 8'h20}) begin
            n_err++; $display("FAIL thresh_below: got irq=%b id=%0d lvl=%h want 1/7/20", irq, irq_id, irq_level);
        end
        intr_src[7] = 1'b0;
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL level_fall_1: got irq=%b want 1", irq);
        end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL level_fall_2: got irq=%b want 0", irq);
        end
        thresh = 8'h00;
        cfg_wr(4'd7, 32'h0);
    endtask

    task automatic test_edge_ack_same();
        cfg_wr(4'd4, 32'h0000_3007);
        intr_src[4] = 1'b1;
        tick();
        n_cmp++;
        if ({irq, irq_id} !== {1'b1, 4'd4}) begin
            n_err++; $display("FAIL same_pre: got irq=%b id=%0d want 1/4", irq, irq_id);
        end
        ack = 1'b1; ack_id = 4'd4;
        tick();
        ack = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL same_suppress: got irq=%b want 0", irq);
        end
        cfg_rd(4'd4, 32'h0000_3007, "same_ip_kept");
        n_cmp++;
        if ({irq, irq_id, irq_level} !== {1'b1, 4'd4, 8'h30}) begin
            n_err++; $display("FAIL same_reassert: got irq=%b id=%0d lvl=%h want 1/4/30", irq, irq_id, irq_level);
        end
        intr_src[4] = 1'b0;
        cfg_wr(4'd4, 32'h0);
    endtask

    task automatic test_cfg_rw();
`ifdef ZEROHETI_CLIC_SHV_EN
        logic [31:0] exp6 = 32'h0000_500F;
`else
        logic [31:0] exp6 = 32'h0000_5007;
`endif
        cfg_wr(4'd6, 32'hFFFF_500F);
        cfg_rd(4'd6, exp6, "rw_id6");
        cfg_wr(4'd6, 32'h0);
        cfg_wr(4'd12, 32'h0000_FF0F);
        cfg_rd(4'd12, 32'h0, "rw_out_of_range");
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL rw_oor_no_irq: got irq=%b want 0", irq);
        end
        cfg_wr(4'd8, 32'h0000_1007);
        cfg_rd(4'd8, 32'h0000_1007, "switch_edge_ip");
        cfg_wr(4'd8, 32'h0000_1001);
        cfg_rd(4'd8, 32'h0000_1001, "switch_level_ip");
        cfg_wr(4'd8, 32'h0);
    endtask

    task automatic test_reset_mid();
        cfg_wr(4'd5, 32'h0000_4007);
        tick();
        n_cmp++;
        if ({irq, irq_id} !== {1'b1, 4'd5}) begin
            n_err++; $display("FAIL mid_pre: got irq=%b id=%0d want 1/5", irq, irq_id);
        end
        rst = 1'b1; cfg_req = 1'b1; cfg_we = 1'b0; cfg_id = 4'd5;
        tick();
        cfg_req = 1'b0;
        n_cmp++;
        if ({irq, irq_id, irq_level, cfg_rvalid, cfg_rdata} !== {1'b0, 4'd0, 8'h00, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL mid_reset: got irq=%b id=%0d lvl=%h rvalid=%b rdata=%h want zeros",
                              irq, irq_id, irq_level, cfg_rvalid, cfg_rdata);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL mid_after: got irq=%b want 0", irq);
        end
        cfg_rd(4'd5, 32'h0, "mid_state_cleared");
    endtask

    initial begin
        rst = 1'b1; intr_src = '0; thresh = 8'h00;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_id = '0; cfg_wdata = '0;
        ack = 1'b0; ack_id = '0;
        #2;
        test_reset();
        test_edge();
        test_arbitration();
        test_level_thresh();
        test_edge_ack_same();
        test_cfg_rw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
